// File: rtl/crossy_pkg.sv
// Shared types and grid defaults for the crossy-roads player logic.
// The hop FSM states and decoded move directions live here so the renderer can reuse them.
package crossy_pkg;

    typedef enum logic [1:0] {
        READY,
        LOCK,
        DEAD,
        WON
    } hop_state_e;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_e;

    localparam int unsigned GRID_ROWS     = 16;
    localparam int unsigned GRID_COLS     = 16;
    localparam int unsigned GRID_START_COL = 8;
    localparam int unsigned HOP_COOLDOWN  = 4;

    // Number of move pulses asserted together; anything other than one is not a move.
    function automatic int unsigned pulseCount(input logic [3:0] pulses);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            n += {31'd0, pulses[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hop_decode.sv
// Turns the four single-cycle button pulses into one move direction.
// Zero or several simultaneous pulses decode to DIR_NONE.
module hop_decode
    import crossy_pkg::*;
(
    input  logic up_p_i,
    input  logic down_p_i,
    input  logic left_p_i,
    input  logic right_p_i,
    output dir_e dir_o
);

    logic [3:0] pulses;

    assign pulses = {up_p_i, down_p_i, left_p_i, right_p_i};

    always_comb begin
        dir_o = DIR_NONE;
        if (pulseCount(pulses) == 1) begin
            if (up_p_i) begin
                dir_o = DIR_UP;
            end else if (down_p_i) begin
                dir_o = DIR_DOWN;
            end else if (left_p_i) begin
                dir_o = DIR_LEFT;
            end else begin
                dir_o = DIR_RIGHT;
            end
        end
    end

endmodule

// File: rtl/hop_controller.sv
// Player position tracker for the crossy-roads grid: bounds-checked hops,
// a post-hop cooldown, and freezing on collision or on reaching the goal row.
module hop_controller
    import crossy_pkg::*;
#(
    parameter int unsigned ROWS      = GRID_ROWS,
    parameter int unsigned COLS      = GRID_COLS,
    parameter int unsigned START_COL = GRID_START_COL,
    parameter int unsigned COOLDOWN  = HOP_COOLDOWN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up_p_i,
    input  logic                    down_p_i,
    input  logic                    left_p_i,
    input  logic                    right_p_i,
    input  logic                    hit_i,
    input  logic                    restart_i,
    output logic [$clog2(ROWS)-1:0] row_o,
    output logic [$clog2(COLS)-1:0] col_o,
    output logic                    moved_o,
    output logic                    win_o,
    output logic                    dead_o
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CLW = $clog2(COLS);
    localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);
    localparam logic [CLW-1:0] COL_START = CLW'(START_COL);
    localparam logic [CW-1:0]  CNT_LOAD  = CW'(COOLDOWN);

    hop_state_e     state_q;
    logic [RW-1:0]  row_q;
    logic [CLW-1:0] col_q;
    logic [CW-1:0]  cnt_q;
    logic           moved_q;
    logic           win_q;
    logic           dead_q;

    logic [RW-1:0]  row_d;
    logic [CLW-1:0] col_d;
    logic           inBounds;
    dir_e           dir;

    hop_decode u_decode (
        .up_p_i    (up_p_i),
        .down_p_i  (down_p_i),
        .left_p_i  (left_p_i),
        .right_p_i (right_p_i),
        .dir_o     (dir)
    );

    // Candidate landing cell; a move that would leave the grid is simply not in bounds.
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        inBounds = 1'b0;
        case (dir)
            DIR_UP: begin
                if (row_q != '0) begin
                    row_d    = row_q - RW'(1);
                    inBounds = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (row_q != ROW_LAST) begin
                    row_d    = row_q + RW'(1);
                    inBounds = 1'b1;
                end
            end
            DIR_LEFT: begin
                if (col_q != '0) begin
                    col_d    = col_q - CLW'(1);
                    inBounds = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (col_q != COL_LAST) begin
                    col_d    = col_q + CLW'(1);
                    inBounds = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // LOCK leaves on the edge where the counter is at one, so the next edge accepts again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
            row_q   <= ROW_LAST;
            col_q   <= COL_START;
            cnt_q   <= '0;
            moved_q <= 1'b0;
            win_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            moved_q <= 1'b0;
            win_q   <= 1'b0;
            if (restart_i) begin
                state_q <= READY;
                row_q   <= ROW_LAST;
                col_q   <= COL_START;
                cnt_q   <= '0;
                dead_q  <= 1'b0;
            end else if (hit_i && (state_q == READY || state_q == LOCK)) begin
                state_q <= DEAD;
                cnt_q   <= '0;
                dead_q  <= 1'b1;
            end else begin
                case (state_q)
                    READY: begin
                        if (inBounds) begin
                            row_q   <= row_d;
                            col_q   <= col_d;
                            moved_q <= 1'b1;
                            if (row_d == '0) begin
                                win_q   <= 1'b1;
                                state_q <= WON;
                            end else if (COOLDOWN > 0) begin
                                state_q <= LOCK;
                                cnt_q   <= CNT_LOAD;
                            end
                        end
                    end
                    LOCK: begin
                        if (cnt_q <= CW'(1)) begin
                            state_q <= READY;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign moved_o = moved_q;
    assign win_o   = win_q;
    assign dead_o  = dead_q;

endmodule

// File: tb/tb_hop_controller.sv
// Directed and randomized checks of hop_controller against a cycle-numbered
// reference model of the player's position, cooldown window and freeze states.
module tb_hop_controller;

    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int START_COL = 8;
    localparam int COOLDOWN  = 4;

    logic       clk;
    logic       reset;
    logic       up_p, down_p, left_p, right_p, hit, restart;
    logic [3:0] row;
    logic [3:0] col;
    logic       moved, win, dead;

    int nChecks;
    int nPass;

    // Reference model: plain integers plus the edge number of the last accepted hop.
    int  edgeNum;
    int  lastHopEdge;
    int  mRow, mCol;
    bit  mDead, mWon, mMoved, mWin;

    hop_controller #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .START_COL (START_COL),
        .COOLDOWN  (COOLDOWN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_p_i    (up_p),
        .down_p_i  (down_p),
        .left_p_i  (left_p),
        .right_p_i (right_p),
        .hit_i     (hit),
        .restart_i (restart),
        .row_o     (row),
        .col_o     (col),
        .moved_o   (moved),
        .win_o     (win),
        .dead_o    (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelHome();
        mRow        = ROWS - 1;
        mCol        = START_COL;
        mDead       = 0;
        mWon        = 0;
        mMoved      = 0;
        mWin        = 0;
        lastHopEdge = -1000;
    endtask

    task automatic modelEdge(input bit u, input bit d, input bit l, input bit r,
                             input bit h, input bit rs);
        int nr, nc;
        edgeNum++;
        mMoved = 0;
        mWin   = 0;
        if (rs) begin
            modelHome();
        end else if (h && !mDead && !mWon) begin
            mDead = 1;
        end else if (!mDead && !mWon && (int'(u) + int'(d) + int'(l) + int'(r)) == 1
                     && edgeNum > lastHopEdge + COOLDOWN) begin
            nr = mRow - int'(u) + int'(d);
            nc = mCol - int'(l) + int'(r);
            if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
                mRow        = nr;
                mCol        = nc;
                mMoved      = 1;
                lastHopEdge = edgeNum;
                if (nr == 0) begin
                    mWon = 1;
                    mWin = 1;
                end
            end
        end
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("FAIL %s at edge %0d: observed=%0d expected=%0d",
                    tag, edgeNum, observed, expected);
    endtask

    task automatic checkOutput();
        checkOne("row",   {28'd0, row},   mRow);
        checkOne("col",   {28'd0, col},   mCol);
        checkOne("moved", {31'd0, moved}, {31'd0, mMoved});
        checkOne("win",   {31'd0, win},   {31'd0, mWin});
        checkOne("dead",  {31'd0, dead},  {31'd0, mDead});
    endtask

    // One clock edge: drive at negedge, let the model take the same edge, sample 1ns later.
    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r,
                                 input bit h, input bit rs);
        @(negedge clk);
        up_p    = u;
        down_p  = d;
        left_p  = l;
        right_p = r;
        hit     = h;
        restart = rs;
        @(posedge clk);
        modelEdge(u, d, l, r, h, rs);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        edgeNum = 0;
        {up_p, down_p, left_p, right_p, hit, restart} = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelHome();
        checkOutput();
        checkOne("reset_row_literal", {28'd0, row}, 32'd15);
        checkOne("reset_col_literal", {28'd0, col}, 32'd8);

        // Hop, cooldown drop at k+4, accept at k+5.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("first_hop_row", {28'd0, row}, 32'd14);
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("cooldown_drop_row", {28'd0, row}, 32'd14);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("after_cooldown_row", {28'd0, row}, 32'd13);
        idle(4);

        // Walk to the left wall, push against it, then step back right.
        for (int i = 0; i < START_COL; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            idle(4);
        end
        checkOne("left_wall_col", {28'd0, col}, 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOne("left_wall_moved", {31'd0, moved}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOne("right_after_wall", {28'd0, col}, 32'd1);
        idle(4);

        // Two pulses on one edge are not a move and do not start a cooldown.
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOne("no_lock_after_double", {28'd0, col}, 32'd2);
        idle(4);

        // Collision beats a same-edge move; restart recovers.
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOne("hit_dead", {31'd0, dead}, 32'd1);
        idle(5);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("dead_frozen_row", {28'd0, row}, 32'd15);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOne("post_restart_row", {28'd0, row}, 32'd14);
        idle(4);

        // Climb to the goal row, then everything but restart is ignored.
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < ROWS - 1; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            if (i != ROWS - 2) idle(4);
        end
        checkOne("goal_win", {31'd0, win}, 32'd1);
        checkOne("goal_row", {28'd0, row}, 32'd0);
        idle(5);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOne("won_ignores_hit", {31'd0, dead}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOne("won_restart_row", {28'd0, row}, 32'd15);

        // Random traffic biased upward so goal, walls and collisions all show up.
        for (int i = 0; i < 1500; i++) begin
            bit u, d, l, r, h, rs;
            u  = ($urandom_range(0, 99) < 35);
            d  = ($urandom_range(0, 99) < 10);
            l  = ($urandom_range(0, 99) < 15);
            r  = ($urandom_range(0, 99) < 15);
            h  = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 99) < 2);
            applyStimulus(u, d, l, r, h, rs);
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
